rpn_sequencer: RTL

- Controller that sequences the calculator's 32-bit operand stack (LIFO, one push or pop per clock, pop data registered one cycle later).
- Turns user button presses into stack pushes of switch values.
- Runs the RPN execute sequence: pop B, pop A, compute A op B, push the result.
- Keeps its own depth count and is the only master of the stack's push/pop strobes.

---
 rtl/rpn_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rpn_sequencer.sv
// RPN calculator sequencer: button edges become stack pushes; exec runs pop B, pop A, compute, push.
// Define RPN_DIV_EN to enable unsigned divide (op 110) and modulo (op 111).
module rpn_sequencer #(
    parameter int MAX_DEPTH = 15,
    parameter int DEPTH_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_enter,
    input  logic               btn_exec,
    input  logic [2:0]         op_sel,
    input  logic [15:0]        sw_data,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [31:0]        stk_wdata,
    input  logic [31:0]        stk_rdata,
    output logic [DEPTH_W-1:0] depth,
    output logic [31:0]        result,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_B,
        S_WAIT_B,
        S_POP_A,
        S_WAIT_A,
        S_EXEC,
        S_PUSH
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

    state_t              state_q, state_d;
    logic                enter_hist_q, exec_hist_q;
    logic                stk_push_q, stk_push_d;
    logic                stk_pop_q, stk_pop_d;
    logic [31:0]         stk_wdata_q, stk_wdata_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [31:0]         result_q, result_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [2:0]          op_q, op_d;

    logic                enter_edge, exec_edge;
    logic                can_push, can_exec;
    logic [31:0]         alu_res;
    logic                alu_ok;

    assign enter_edge = btn_enter & ~enter_hist_q;
    assign exec_edge  = btn_exec & ~exec_hist_q;
    assign can_push   = (depth_q < DEPTH_FULL);
    assign can_exec   = (depth_q >= DEPTH_TWO);

    // Operand A is the deeper entry, so A - B follows the usual RPN reading order.
    always_comb begin
        alu_res = 32'd0;
        alu_ok  = 1'b1;
        case (op_q)
            3'b000:  alu_res = a_q + b_q;
            3'b001:  alu_res = a_q - b_q;
            3'b010:  alu_res = a_q * b_q;
            3'b011:  alu_res = a_q & b_q;
            3'b100:  alu_res = a_q | b_q;
            3'b101:  alu_res = a_q ^ b_q;
`ifdef RPN_DIV_EN
            3'b110: begin
                if (b_q == 32'd0) begin
                    alu_ok = 1'b0;
                end else begin
                    alu_res = a_q / b_q;
                end
            end
            3'b111: begin
                if (b_q == 32'd0) begin
                    alu_ok = 1'b0;
                end else begin
                    alu_res = a_q % b_q;
                end
            end
`endif
            default: alu_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter wins over exec when both edges land in the same IDLE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!enter_edge && exec_edge && can_exec) begin
                    state_d = S_POP_B;
                end
            end
            S_POP_B:  state_d = S_WAIT_B;
            S_WAIT_B: state_d = S_POP_A;
            S_POP_A:  state_d = S_WAIT_A;
            S_WAIT_A: state_d = S_EXEC;
            S_EXEC:   state_d = alu_ok ? S_PUSH : S_IDLE;
            S_PUSH:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are computed one cycle early so they are registered in the state they belong to.
    always_comb begin
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        stk_wdata_d = stk_wdata_q;
        depth_d     = depth_q;
        result_d    = result_q;
        err_d       = err_q;
        busy_d      = (state_d != S_IDLE);
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        case (state_q)
            S_IDLE: begin
                if (enter_edge) begin
                    if (can_push) begin
                        stk_push_d  = 1'b1;
                        stk_wdata_d = {16'b0, sw_data};
                        depth_d     = depth_q + DEPTH_ONE;
                        err_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (exec_edge) begin
                    if (can_exec) begin
                        op_d      = op_sel;
                        stk_pop_d = 1'b1;
                        depth_d   = depth_q - DEPTH_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT_B: begin
                b_d       = stk_rdata;
                stk_pop_d = 1'b1;
                depth_d   = depth_q - DEPTH_ONE;
            end
            S_WAIT_A: begin
                a_d = stk_rdata;
            end
            S_EXEC: begin
                if (alu_ok) begin
                    result_d    = alu_res;
                    stk_push_d  = 1'b1;
                    stk_wdata_d = alu_res;
                    depth_d     = depth_q + DEPTH_ONE;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enter_hist_q <= 1'b0;
            exec_hist_q  <= 1'b0;
            stk_push_q   <= 1'b0;
            stk_pop_q    <= 1'b0;
            stk_wdata_q  <= 32'd0;
            depth_q      <= '0;
            result_q     <= 32'd0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            op_q         <= 3'd0;
        end else begin
            enter_hist_q <= btn_enter;
            exec_hist_q  <= btn_exec;
            stk_push_q   <= stk_push_d;
            stk_pop_q    <= stk_pop_d;
            stk_wdata_q  <= stk_wdata_d;
            depth_q      <= depth_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
        end
    end

    assign stk_push  = stk_push_q;
    assign stk_pop   = stk_pop_q;
    assign stk_wdata = stk_wdata_q;
    assign depth     = depth_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
